// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: NOP encoding, reset PC, word alignment
// mask and the instruction-fetch state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = ~32'h3;

  // Fetch FSM encoding, kept as plain constants for older tooling downstream.
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HAVE = 2'd2;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register and next-PC mux (hold / +4 / aligned redirect).
// next_pc is exposed so the fetch stage can issue it as the request address.
module if_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_t     sel,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] next_pc
);

  // Wraps modulo 2^32 by construction: FFFF_FFFC + 4 = 0.
  assign pc_plus_4 = pc + 32'd4;

  always_comb begin
    // NOTE: every path assigns next_pc via this default, so no latch is inferred.
    next_pc = pc;
    case (sel)
      PC_INC:      next_pc = pc_plus_4;
      PC_REDIRECT: next_pc = align_word(redirect_pc);
      default:     next_pc = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: one outstanding imem request, single-word
// buffer, stall/redirect handling and NOP bubbles toward the IF/ID register.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        IF_valid,
  output logic [31:0] IF_ins,
  output logic [31:0] IF_pc_plus_4
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] instr_buf;
  logic        drop;
  logic        drop_nxt;
  logic        buf_load;
  logic        req_raw;
  logic        redirect;
  pc_sel_t     pc_sel;
  logic [31:0] pc;
  logic [31:0] next_pc;

  // Redirect is masked in reset so imem_addr reads RESET_PC while rst_n=0.
  assign redirect = redirect_valid & rst_n;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus_4   (IF_pc_plus_4),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    pc_sel    = PC_HOLD;
    req_raw   = 1'b0;
    buf_load  = 1'b0;
    IF_valid  = 1'b0;
    IF_ins    = NOP_INSTR;
    case (state)
      ST_REQ: begin
        req_raw   = 1'b1;
        state_nxt = ST_WAIT;
        if (redirect) pc_sel = PC_REDIRECT;
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_sel   = PC_REDIRECT;
          drop_nxt = 1'b1;
        end
        // A response racing a redirect belongs to the old path: always dropped.
        if (imem_rvalid) begin
          if (drop || redirect) begin
            drop_nxt  = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            buf_load  = 1'b1;
            state_nxt = ST_HAVE;
          end
        end
      end
      ST_HAVE: begin
        if (redirect) begin
          req_raw   = 1'b1;
          pc_sel    = PC_REDIRECT;
          state_nxt = ST_WAIT;
        end else begin
          IF_valid = 1'b1;
          IF_ins   = instr_buf;
          if (!stall) begin
            req_raw   = 1'b1;
            pc_sel    = PC_INC;
            state_nxt = ST_WAIT;
          end
        end
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  assign imem_req  = req_raw & rst_n;
  assign imem_addr = next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_REQ;
      drop      <= 1'b0;
      instr_buf <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (buf_load) instr_buf <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table from reset with a
// 1-cycle memory, then hand sequences for redirect-in-WAIT and async reset.
module tb_if_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        IF_valid;
  logic [31:0] IF_ins;
  logic [31:0] IF_pc_plus_4;

  int n_total = 0;
  int n_pass  = 0;

  // Memory model state
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[15];

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .IF_valid       (IF_valid),
    .IF_ins         (IF_ins),
    .IF_pc_plus_4   (IF_pc_plus_4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0003;
      default:       return {16'h3C00, a[15:0]};
    endcase
  endfunction

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rq, input logic [31:0] ad, input logic v,
                              input logic [31:0] ins, input logic [31:0] pc4);
    vec_t r;
    r.stall = st; r.redir = rd; r.rpc = rpc; r.e_req = rq; r.e_addr = ad;
    r.e_valid = v; r.e_ins = ins; r.e_pc4 = pc4;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Advance one clock; the memory model answers lat cycles after a request.
  task automatic tick();
    logic        req_s;
    logic [31:0] addr_s;
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge clk);
    #1;
    if (cnt > 0) cnt--;
    if (req_s) begin
      cnt       = lat;
      pend_addr = addr_s;
    end
    imem_rvalid = (cnt == 1);
    imem_rdata  = (cnt == 1) ? mem_word(pend_addr) : 32'h0;
  endtask

  task automatic check_outs(input string tag, input logic rq, input logic [31:0] ad,
                            input logic v, input logic [31:0] ins, input logic [31:0] pc4);
    check({tag, "_req"}, {31'h0, imem_req}, {31'h0, rq});
    if (rq) check({tag, "_addr"}, imem_addr, ad);
    check({tag, "_valid"}, {31'h0, IF_valid}, {31'h0, v});
    check({tag, "_ins"}, IF_ins, ins);
    check({tag, "_pc4"}, IF_pc_plus_4, pc4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cnt = 0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait a bounded number of cycles for IF_valid; a timeout is a failed check.
  task automatic wait_valid(input string tag, input logic [31:0] ins, input logic [31:0] pc4);
    bit got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (IF_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_arrived"}, {31'h0, got}, 32'h1);
    if (got) begin
      check({tag, "_ins"}, IF_ins, ins);
      check({tag, "_pc4"}, IF_pc_plus_4, pc4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #3;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    check("reset_addr", imem_addr, 32'h0);

    //            stall redir rpc            req addr          valid ins            pc4
    vecs[0]  = mk(0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0000_0004);
    vecs[1]  = mk(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0000_0004);
    vecs[2]  = mk(1, 0, 32'h0,          0, 32'h0,         1, 32'h2008_0005,  32'h0000_0004);
    vecs[3]  = mk(1, 0, 32'h0,          0, 32'h0,         1, 32'h2008_0005,  32'h0000_0004);
    vecs[4]  = mk(1, 0, 32'h0,          0, 32'h0,         1, 32'h2008_0005,  32'h0000_0004);
    vecs[5]  = mk(0, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h2008_0005,  32'h0000_0004);
    vecs[6]  = mk(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0000_0008);
    vecs[7]  = mk(1, 1, 32'h0000_0200,  1, 32'h0000_0200, 0, 32'h0,          32'h0000_0008);
    vecs[8]  = mk(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0000_0204);
    vecs[9]  = mk(0, 1, 32'hFFFF_FFFF,  1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0000_0204);
    vecs[10] = mk(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0000_0000);
    vecs[11] = mk(0, 0, 32'h0,          1, 32'h0000_0000, 1, 32'h3C00_FFFC,  32'h0000_0000);
    vecs[12] = mk(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0000_0004);
    vecs[13] = mk(0, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h2008_0005,  32'h0000_0004);
    vecs[14] = mk(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,          32'h0000_0008);

    // Table run: 1-cycle memory straight out of reset.
    lat = 1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_ins, vecs[i].e_pc4);
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0;

    // Redirect while WAITing on a 3-cycle memory: old word must be dropped.
    lat = 3;
    do_reset();
    #2;
    check_outs("r3_req0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    #2;
    check("r3_wait_req", {31'h0, imem_req}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #2;
    check("r3_pc4_after_redir", IF_pc_plus_4, 32'h0000_0104);
    tick();
    #2;
    check("r3_rvalid_seen", {31'h0, imem_rvalid}, 32'h1);
    check("r3_dropped_valid", {31'h0, IF_valid}, 32'h0);
    tick();
    #2;
    check_outs("r3_rereq", 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0104);
    tick();
    wait_valid("r3_new", 32'h3C00_0100, 32'h0000_0104);

    // Async reset mid-WAIT, then a stale rvalid in REQ must be ignored.
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    #2;
    check_outs("ar_req", 1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h4);
    tick();
    redirect_valid = 1'b0;
    #2;
    check("ar_wait_pc4", IF_pc_plus_4, 32'h0000_0044);
    #1;
    rst_n = 1'b0;
    cnt = 0;
    #1;
    check_outs("ar_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    check("ar_async_addr", imem_addr, 32'h0);
    tick();
    #2;
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check_outs("ar_first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    tick();
    #2;
    check("ar_stale_ignored", {31'h0, IF_valid}, 32'h0);
    tick();
    wait_valid("ar_fetch0", 32'h2008_0005, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
